// File: rtl/svx32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// svx32_mem_arbiter
//   Shares one external memory bus between the svx32_core instruction-fetch
//   port (read-only) and the mem-unit data port (read/write). Only one bus
//   transaction is outstanding at a time. The data port wins contention, but
//   after MAX_D_STREAK consecutive data grants with fetch waiting, fetch is
//   granted. An optional timeout turns a hung bus access into an error
//   completion towards the owning port.
//
// Parameters
//   MAX_D_STREAK  max consecutive data grants while fetch waits (>= 1)
//   TIMEOUT_CYC   BUSY cycles without bus ack before error completion (0 = off)
//
// Ports
//   pil_clk, pil_rst_n              clock / async active-low reset
//   pil_i_req, piv_i_addr           fetch request (held until pol_i_ack)
//   pol_i_ack, pov_i_rdata, pol_i_err   fetch completion pulse, data, timeout
//   pil_d_req, pil_d_wen, piv_d_addr, piv_d_wdata, piv_d_byte_sel
//                                   data request (held until pol_d_ack)
//   pol_d_ack, pov_d_rdata, pol_d_err   data completion pulse, data, timeout
//   pol_bus_req, pol_bus_wen, pov_bus_addr, pov_bus_wdata, pov_bus_byte_sel
//                                   bus request and fields (held while req=1)
//   pil_bus_ack, piv_bus_rdata      bus completion pulse and read data
//   pol_busy                        high while a transaction is in flight
// -----------------------------------------------------------------------------
module svx32_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic        pil_clk,
  input  logic        pil_rst_n,
  // fetch port
  input  logic        pil_i_req,
  input  logic [31:0] piv_i_addr,
  output logic        pol_i_ack,
  output logic [31:0] pov_i_rdata,
  output logic        pol_i_err,
  // data port
  input  logic        pil_d_req,
  input  logic        pil_d_wen,
  input  logic [31:0] piv_d_addr,
  input  logic [31:0] piv_d_wdata,
  input  logic [3:0]  piv_d_byte_sel,
  output logic        pol_d_ack,
  output logic [31:0] pov_d_rdata,
  output logic        pol_d_err,
  // external bus
  output logic        pol_bus_req,
  output logic        pol_bus_wen,
  output logic [31:0] pov_bus_addr,
  output logic [31:0] pov_bus_wdata,
  output logic [3:0]  pov_bus_byte_sel,
  input  logic        pil_bus_ack,
  input  logic [31:0] piv_bus_rdata,
  output logic        pol_busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SW-1:0] STREAK_MAX  = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TCOUNT_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcount;

  logic grant_d;
  logic grant_i;
  logic acks_idle;
  logic timeout_hit;
  logic done;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    timeout_hit = 1'b0;
    // While a completion pulse is out, the owner still holds its request.
    // Holding off arbitration for that one cycle masks the stale request and
    // lets both held requests compete cleanly on the next cycle.
    acks_idle   = !pol_i_ack && !pol_d_ack;
    if (state == IDLE && acks_idle) begin
      if (pil_d_req && (!pil_i_req || streak != STREAK_MAX)) grant_d = 1'b1;
      else if (pil_i_req)                                   grant_i = 1'b1;
    end
    if (TIMEOUT_CYC != 0 && tcount == TCOUNT_LAST) timeout_hit = 1'b1;
    // A bus ack in the same cycle as the timeout wins (normal completion).
    done = (state != IDLE) && (pil_bus_ack || timeout_hit);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge pil_clk or negedge pil_rst_n) begin
    if (!pil_rst_n) begin
      // An in-flight transaction is simply dropped: no port sees an ack.
      state            <= IDLE;
      streak           <= '0;
      tcount           <= '0;
      pol_busy         <= 1'b0;
      pol_bus_req      <= 1'b0;
      pol_bus_wen      <= 1'b0;
      pov_bus_addr     <= '0;
      pov_bus_wdata    <= '0;
      pov_bus_byte_sel <= '0;
      pol_i_ack        <= 1'b0;
      pov_i_rdata      <= '0;
      pol_i_err        <= 1'b0;
      pol_d_ack        <= 1'b0;
      pov_d_rdata      <= '0;
      pol_d_err        <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses by default.
      pol_i_ack   <= 1'b0;
      pov_i_rdata <= '0;
      pol_i_err   <= 1'b0;
      pol_d_ack   <= 1'b0;
      pov_d_rdata <= '0;
      pol_d_err   <= 1'b0;

      case (state)
        IDLE: begin
          // Late bus acks (after a timeout) land here and are ignored.
          tcount <= '0;
          if (grant_d) begin
            state            <= BUSY_D;
            pol_busy         <= 1'b1;
            pol_bus_req      <= 1'b1;
            pol_bus_wen      <= pil_d_wen;
            pov_bus_addr     <= piv_d_addr;
            pov_bus_wdata    <= piv_d_wdata;
            pov_bus_byte_sel <= piv_d_byte_sel;
            // grant_d with fetch waiting implies streak < STREAK_MAX, so the
            // increment saturates by construction.
            streak           <= pil_i_req ? streak + 1'b1 : '0;
          end else if (grant_i) begin
            state            <= BUSY_I;
            pol_busy         <= 1'b1;
            pol_bus_req      <= 1'b1;
            pol_bus_wen      <= 1'b0;
            pov_bus_addr     <= piv_i_addr;
            pov_bus_wdata    <= '0;
            pov_bus_byte_sel <= 4'hF;
            streak           <= '0;
          end else if (!pil_i_req) begin
            streak <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          if (done) begin
            state            <= IDLE;
            pol_busy         <= 1'b0;
            pol_bus_req      <= 1'b0;
            pol_bus_wen      <= 1'b0;
            pov_bus_addr     <= '0;
            pov_bus_wdata    <= '0;
            pov_bus_byte_sel <= '0;
            tcount           <= '0;
            if (state == BUSY_D) begin
              pol_d_ack   <= 1'b1;
              pol_d_err   <= !pil_bus_ack;
              // Writes and timeouts return zero data.
              pov_d_rdata <= (pil_bus_ack && !pol_bus_wen) ? piv_bus_rdata : '0;
            end else begin
              pol_i_ack   <= 1'b1;
              pol_i_err   <= !pil_bus_ack;
              pov_i_rdata <= pil_bus_ack ? piv_bus_rdata : '0;
            end
          end else if (TIMEOUT_CYC != 0) begin
            tcount <= tcount + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          pol_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_svx32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_svx32_mem_arbiter
//   Directed self-checking bench for svx32_mem_arbiter with MAX_D_STREAK=4 and
//   TIMEOUT_CYC=8. Inputs change 1 ns after a rising edge; outputs are sampled
//   at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_svx32_mem_arbiter;

  localparam logic [31:0] I_ADDR = 32'h0000_0100;
  localparam logic [31:0] D_ADDR = 32'h0000_2000;

  logic        pil_clk = 1'b0;
  logic        pil_rst_n;
  logic        pil_i_req;
  logic [31:0] piv_i_addr;
  logic        pol_i_ack;
  logic [31:0] pov_i_rdata;
  logic        pol_i_err;
  logic        pil_d_req;
  logic        pil_d_wen;
  logic [31:0] piv_d_addr;
  logic [31:0] piv_d_wdata;
  logic [3:0]  piv_d_byte_sel;
  logic        pol_d_ack;
  logic [31:0] pov_d_rdata;
  logic        pol_d_err;
  logic        pol_bus_req;
  logic        pol_bus_wen;
  logic [31:0] pov_bus_addr;
  logic [31:0] pov_bus_wdata;
  logic [3:0]  pov_bus_byte_sel;
  logic        pil_bus_ack;
  logic [31:0] piv_bus_rdata;
  logic        pol_busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int i_ack_cnt    = 0;
  int d_ack_cnt    = 0;

  svx32_mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYC(8)) dut (
    .pil_clk         (pil_clk),
    .pil_rst_n       (pil_rst_n),
    .pil_i_req       (pil_i_req),
    .piv_i_addr      (piv_i_addr),
    .pol_i_ack       (pol_i_ack),
    .pov_i_rdata     (pov_i_rdata),
    .pol_i_err       (pol_i_err),
    .pil_d_req       (pil_d_req),
    .pil_d_wen       (pil_d_wen),
    .piv_d_addr      (piv_d_addr),
    .piv_d_wdata     (piv_d_wdata),
    .piv_d_byte_sel  (piv_d_byte_sel),
    .pol_d_ack       (pol_d_ack),
    .pov_d_rdata     (pov_d_rdata),
    .pol_d_err       (pol_d_err),
    .pol_bus_req     (pol_bus_req),
    .pol_bus_wen     (pol_bus_wen),
    .pov_bus_addr    (pov_bus_addr),
    .pov_bus_wdata   (pov_bus_wdata),
    .pov_bus_byte_sel(pov_bus_byte_sel),
    .pil_bus_ack     (pil_bus_ack),
    .piv_bus_rdata   (piv_bus_rdata),
    .pol_busy        (pol_busy)
  );

  always #5 pil_clk = ~pil_clk;

  // Count completion pulses on the falling edge, mid-cycle.
  always @(negedge pil_clk) begin
    if (pol_i_ack === 1'b1) i_ack_cnt++;
    if (pol_d_ack === 1'b1) d_ack_cnt++;
  end

  task automatic tick();
    @(posedge pil_clk);
    #1;
  endtask

  // Wait (bounded) for bus_req, capture the granted fields, wait lat cycles,
  // then pulse the bus ack for one cycle. Returns 1 ns after the completion
  // edge, i.e. in the cycle where the port ack is visible.
  task automatic serve(input int lat, input logic [31:0] data,
                       output logic [31:0] addr, output logic wen, output bit ok);
    int n = 0;
    while (pol_bus_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    ok   = (pol_bus_req === 1'b1);
    addr = pov_bus_addr;
    wen  = pol_bus_wen;
    if (ok) begin
      repeat (lat) tick();
      pil_bus_ack   = 1'b1;
      piv_bus_rdata = data;
      tick();
      pil_bus_ack   = 1'b0;
      piv_bus_rdata = '0;
    end
  endtask

  task automatic test_reset();
    pil_rst_n = 1'b0;
    pil_i_req = 0; piv_i_addr = '0;
    pil_d_req = 0; pil_d_wen = 0; piv_d_addr = '0; piv_d_wdata = '0; piv_d_byte_sel = '0;
    pil_bus_ack = 0; piv_bus_rdata = '0;
    repeat (3) tick();
    tests_run++;
    if ({pol_bus_req, pol_busy, pol_i_ack, pol_d_ack, pol_i_err, pol_d_err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {pol_bus_req, pol_busy, pol_i_ack, pol_d_ack, pol_i_err, pol_d_err});
    end
    tests_run++;
    if ({pov_bus_addr, pov_bus_wdata, pov_i_rdata, pov_d_rdata, pov_bus_byte_sel, pol_bus_wen} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h irdata=%h drdata=%h sel=%h wen=%b want all 0",
               pov_bus_addr, pov_bus_wdata, pov_i_rdata, pov_d_rdata, pov_bus_byte_sel, pol_bus_wen);
    end
    pil_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_only();
    logic [31:0] a; logic w; bit ok; int d0;
    d0 = d_ack_cnt;
    pil_i_req = 1; piv_i_addr = I_ADDR;
    tick();
    tests_run++;
    if (pol_bus_req !== 1'b1 || pol_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_grant_latency: bus_req=%b busy=%b want 1 1", pol_bus_req, pol_busy);
    end
    tests_run++;
    if (pov_bus_addr !== I_ADDR || pol_bus_wen !== 1'b0 || pov_bus_wdata !== '0 || pov_bus_byte_sel !== 4'hF) begin
      tests_failed++;
      $display("FAIL fetch_bus_fields: addr=%h wen=%b wdata=%h sel=%h want %h 0 0 f",
               pov_bus_addr, pol_bus_wen, pov_bus_wdata, pov_bus_byte_sel, I_ADDR);
    end
    serve(2, 32'h0000_0013, a, w, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL fetch_serve_timeout: bus_req never seen");
    end
    tests_run++;
    if (pol_i_ack !== 1'b1 || pov_i_rdata !== 32'h13 || pol_i_err !== 1'b0 || pol_bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_complete: ack=%b rdata=%h err=%b bus_req=%b want 1 00000013 0 0",
               pol_i_ack, pov_i_rdata, pol_i_err, pol_bus_req);
    end
    pil_i_req = 0;
    tick();
    tests_run++;
    if (pol_i_ack !== 1'b0 || pov_i_rdata !== '0 || pol_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_pulse_end: ack=%b rdata=%h busy=%b want 0 0 0", pol_i_ack, pov_i_rdata, pol_busy);
    end
    tests_run++;
    if (d_ack_cnt !== d0) begin
      tests_failed++;
      $display("FAIL fetch_no_d_ack: d_ack pulses=%0d want %0d", d_ack_cnt, d0);
    end
  endtask

  task automatic test_data_rw();
    logic [31:0] a; logic w; bit ok;
    pil_d_req = 1; pil_d_wen = 1; piv_d_addr = D_ADDR;
    piv_d_wdata = 32'hDEAD_BEEF; piv_d_byte_sel = 4'b0011;
    tick();
    // Requester changes during BUSY must not reach the bus.
    piv_d_addr = 32'hFFFF_0000; piv_d_wdata = 32'h1111_1111; piv_d_byte_sel = 4'b1100; pil_d_wen = 0;
    tick();
    tests_run++;
    if (pol_bus_req !== 1'b1 || pol_bus_wen !== 1'b1 || pov_bus_addr !== D_ADDR ||
        pov_bus_wdata !== 32'hDEAD_BEEF || pov_bus_byte_sel !== 4'b0011) begin
      tests_failed++;
      $display("FAIL dwrite_bus_fields: req=%b wen=%b addr=%h wdata=%h sel=%b want 1 1 %h deadbeef 0011",
               pol_bus_req, pol_bus_wen, pov_bus_addr, pov_bus_wdata, pov_bus_byte_sel, D_ADDR);
    end
    serve(0, 32'h1234_5678, a, w, ok);
    tests_run++;
    if (!ok || pol_d_ack !== 1'b1 || pov_d_rdata !== '0 || pol_d_err !== 1'b0 || pol_i_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL dwrite_complete: ok=%b ack=%b rdata=%h err=%b iack=%b want 1 1 0 0 0",
               ok, pol_d_ack, pov_d_rdata, pol_d_err, pol_i_ack);
    end
    pil_d_req = 0;
    tick();
    // Data read returns bus data.
    pil_d_req = 1; pil_d_wen = 0; piv_d_addr = 32'h0000_3000; piv_d_byte_sel = 4'hF;
    serve(1, 32'hCAFE_F00D, a, w, ok);
    tests_run++;
    if (!ok || a !== 32'h0000_3000 || w !== 1'b0 || pol_d_ack !== 1'b1 || pov_d_rdata !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL dread_complete: ok=%b addr=%h wen=%b ack=%b rdata=%h want 1 00003000 0 1 cafef00d",
               ok, a, w, pol_d_ack, pov_d_rdata);
    end
    pil_d_req = 0;
    tick();
  endtask

  task automatic test_streak();
    logic [31:0] a; logic w; bit ok; bit exp_i;
    int seq_err = 0;
    pil_i_req = 1; piv_i_addr = I_ADDR;
    pil_d_req = 1; pil_d_wen = 0; piv_d_addr = D_ADDR; piv_d_byte_sel = 4'hF;
    for (int g = 0; g < 10; g++) begin
      exp_i = (g % 5 == 4);
      serve(0, 32'h100 + g, a, w, ok);
      tests_run++;
      if (!ok || a !== (exp_i ? I_ADDR : D_ADDR) || pol_i_ack !== exp_i || pol_d_ack !== !exp_i) begin
        tests_failed++;
        seq_err++;
        $display("FAIL streak_grant_%0d: ok=%b addr=%h iack=%b dack=%b want addr=%h iack=%b dack=%b",
                 g, ok, a, pol_i_ack, pol_d_ack, exp_i ? I_ADDR : D_ADDR, exp_i, !exp_i);
      end
    end
    pil_i_req = 0; pil_d_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int n = 0; int i0, d0;
    pil_d_req = 1; pil_d_wen = 0; piv_d_addr = 32'h0000_4000; piv_d_byte_sel = 4'hF;
    tick();
    while (pol_bus_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    tests_run++;
    if (n !== 8) begin
      tests_failed++;
      $display("FAIL timeout_busy_cycles: got %0d want 8", n);
    end
    tests_run++;
    if (pol_d_ack !== 1'b1 || pol_d_err !== 1'b1 || pov_d_rdata !== '0 || pol_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_complete: ack=%b err=%b rdata=%h busy=%b want 1 1 0 0",
               pol_d_ack, pol_d_err, pov_d_rdata, pol_busy);
    end
    pil_d_req = 0;
    tick();
    i0 = i_ack_cnt; d0 = d_ack_cnt;
    pil_bus_ack = 1; piv_bus_rdata = 32'h0000_0BAD;
    tick();
    pil_bus_ack = 0; piv_bus_rdata = '0;
    tick();
    tests_run++;
    if (i_ack_cnt !== i0 || d_ack_cnt !== d0 || pol_d_err !== 1'b0 || pol_busy !== 1'b0 || pol_bus_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_ack_ignored: iacks=%0d dacks=%0d err=%b busy=%b req=%b want %0d %0d 0 0 0",
               i_ack_cnt, d_ack_cnt, pol_d_err, pol_busy, pol_bus_req, i0, d0);
    end
  endtask

  task automatic test_ack_vs_timeout();
    logic [31:0] a; logic w; bit ok;
    pil_i_req = 1; piv_i_addr = 32'h0000_0200;
    tick();
    // bus_req is visible now (count 0); ack in the 8th BUSY cycle (count 7).
    serve(7, 32'h55AA_55AA, a, w, ok);
    tests_run++;
    if (!ok || pol_i_ack !== 1'b1 || pol_i_err !== 1'b0 || pov_i_rdata !== 32'h55AA_55AA) begin
      tests_failed++;
      $display("FAIL ack_wins_timeout: ok=%b ack=%b err=%b rdata=%h want 1 1 0 55aa55aa",
               ok, pol_i_ack, pol_i_err, pov_i_rdata);
    end
    pil_i_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] a; logic w; bit ok; int d0;
    d0 = d_ack_cnt;
    pil_d_req = 1; pil_d_wen = 1; piv_d_addr = 32'h0000_6000;
    piv_d_wdata = 32'hA5A5_A5A5; piv_d_byte_sel = 4'hF;
    tick();
    tests_run++;
    if (pol_bus_req !== 1'b1 || pol_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: bus_req=%b busy=%b want 1 1", pol_bus_req, pol_busy);
    end
    #2 pil_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pol_bus_req, pol_busy, pol_bus_wen, pov_bus_addr, pov_bus_wdata, pov_bus_byte_sel} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: req=%b busy=%b wen=%b addr=%h wdata=%h sel=%h want all 0",
               pol_bus_req, pol_busy, pol_bus_wen, pov_bus_addr, pov_bus_wdata, pov_bus_byte_sel);
    end
    pil_d_req = 0;
    pil_i_req = 1; piv_i_addr = 32'h0000_0500;
    tick();
    tick();
    pil_rst_n = 1'b1;
    serve(0, 32'h0000_0777, a, w, ok);
    tests_run++;
    if (!ok || a !== 32'h0000_0500 || w !== 1'b0 || pol_i_ack !== 1'b1 || pov_i_rdata !== 32'h777) begin
      tests_failed++;
      $display("FAIL rst_first_grant: ok=%b addr=%h wen=%b iack=%b rdata=%h want 1 00000500 0 1 00000777",
               ok, a, w, pol_i_ack, pov_i_rdata);
    end
    tests_run++;
    if (d_ack_cnt !== d0) begin
      tests_failed++;
      $display("FAIL rst_no_d_ack: d_ack pulses=%0d want %0d", d_ack_cnt, d0);
    end
    pil_i_req = 0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_data_rw();
    test_streak();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
